// File: rtl/vec_mul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vec_mul_pkg : precision encoding and element-boundary helpers            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package vec_mul_pkg;

  typedef enum logic [1:0] {
    PREC_8    = 2'b00,
    PREC_16   = 2'b01,
    PREC_32   = 2'b10,
    PREC_RSVD = 2'b11
  } prec_e;

  localparam int LANE_W     = 8;
  localparam int MAX_BLOCKS = 512;

  function automatic int elem_width(prec_e prec);
    case (prec)
      PREC_16: return 16;
      PREC_32: return 32;
      default: return LANE_W;
    endcase
  endfunction

  // Bit b is set when carry-select block b starts a new element (carry is cut there).
  function automatic logic [MAX_BLOCKS-1:0] elem_lsb_mask(prec_e prec, int data_w, int block_w = 4);
    logic [MAX_BLOCKS-1:0] m;
    int w;
    m = '0;
    w = elem_width(prec);
    for (int b = 0; b < MAX_BLOCKS; b++)
      m[b] = (b < data_w / block_w) && (((b * block_w) % w) == 0);
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csel_inc_block.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csel_inc_block : dual-rail incrementer slice (carry-in 0 / carry-in 1)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module csel_inc_block #(
  parameter int BLOCK_W = 4
) (
  input  logic [BLOCK_W-1:0] a,
  output logic [BLOCK_W-1:0] sum0,
  output logic [BLOCK_W-1:0] sum1,
  output logic               cout0,
  output logic               cout1
);

  assign sum0  = a;
  assign cout0 = 1'b0;
  assign {cout1, sum1} = {1'b0, a} + {{BLOCK_W{1'b0}}, 1'b1};

endmodule
`default_nettype wire

// File: rtl/pipelined_csel_negator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_csel_negator : per-element two's-complement negate, pipelined  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipelined_csel_negator
  import vec_mul_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int BLOCK_W     = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [1:0]           in_prec,
  input  logic [DATA_W/8-1:0]  in_neg,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [DATA_W/8-1:0]  out_ovf,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int c_nblk  = DATA_W / BLOCK_W;
  localparam int c_nbyte = DATA_W / LANE_W;

  prec_e              w_in_prec;
  logic [c_nbyte-1:0] w_neg_eff;
  logic [DATA_W-1:0]  w_opnd;
  logic [c_nblk-1:0]  w_blk_mask;
  logic [c_nblk-1:0]  w_lsb_cin;
  logic [DATA_W-1:0]  w_sum0, w_sum1;
  logic [c_nblk-1:0]  w_cout0, w_cout1;

  logic               w_src_valid;
  logic [DATA_W-1:0]  w_src_sum0, w_src_sum1;
  logic [c_nblk-1:0]  w_src_cout0, w_src_cout1, w_src_mask, w_src_lcin;
  logic [c_nbyte-1:0] w_src_neg;
  prec_e              w_src_prec;
  logic [TAG_W-1:0]   w_src_tag;

  logic               w_out_load;
  logic [DATA_W-1:0]  w_res;
  logic [c_nbyte-1:0] w_ovf;

  assign w_in_prec  = prec_e'(in_prec);
  assign w_blk_mask = c_nblk'(elem_lsb_mask(w_in_prec, DATA_W, BLOCK_W));

  // Broadcast each element's lowest-byte negate bit across the element, then invert.
  always_comb begin
    w_neg_eff = '0;
    w_opnd    = in_data;
    for (int k = 0; k < c_nbyte; k++) begin
      case (w_in_prec)
        PREC_8:  w_neg_eff[k] = in_neg[k];
        PREC_16: w_neg_eff[k] = in_neg[k & ~1];
        PREC_32: w_neg_eff[k] = in_neg[k & ~3];
        default: w_neg_eff[k] = 1'b0;
      endcase
      if (w_neg_eff[k])
        w_opnd[k*LANE_W +: LANE_W] = ~in_data[k*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    w_lsb_cin = '0;
    for (int b = 0; b < c_nblk; b++)
      w_lsb_cin[b] = w_blk_mask[b] & w_neg_eff[(b * BLOCK_W) / LANE_W];
  end

  for (genvar b = 0; b < c_nblk; b++) begin : g_blk
    csel_inc_block #(.BLOCK_W(BLOCK_W)) u_blk (
      .a     (w_opnd[b*BLOCK_W +: BLOCK_W]),
      .sum0  (w_sum0[b*BLOCK_W +: BLOCK_W]),
      .sum1  (w_sum1[b*BLOCK_W +: BLOCK_W]),
      .cout0 (w_cout0[b]),
      .cout1 (w_cout1[b])
    );
  end

  assign w_out_load = !out_valid || out_ready;

  if (PIPE_STAGES == 2) begin : g_stage1
    logic               r_valid;
    logic [DATA_W-1:0]  r_sum0, r_sum1;
    logic [c_nblk-1:0]  r_cout0, r_cout1, r_mask, r_lcin;
    logic [c_nbyte-1:0] r_neg;
    prec_e              r_prec;
    logic [TAG_W-1:0]   r_tag;
    logic               w_s1_load;

    assign w_s1_load = !r_valid || w_out_load;
    assign in_ready  = w_s1_load;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_sum0  <= '0;
        r_sum1  <= '0;
        r_cout0 <= '0;
        r_cout1 <= '0;
        r_mask  <= '0;
        r_lcin  <= '0;
        r_neg   <= '0;
        r_prec  <= PREC_8;
        r_tag   <= '0;
      end else if (w_s1_load) begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_sum0  <= w_sum0;
          r_sum1  <= w_sum1;
          r_cout0 <= w_cout0;
          r_cout1 <= w_cout1;
          r_mask  <= w_blk_mask;
          r_lcin  <= w_lsb_cin;
          r_neg   <= w_neg_eff;
          r_prec  <= w_in_prec;
          r_tag   <= in_tag;
        end
      end
    end

    assign w_src_valid = r_valid;
    assign w_src_sum0  = r_sum0;
    assign w_src_sum1  = r_sum1;
    assign w_src_cout0 = r_cout0;
    assign w_src_cout1 = r_cout1;
    assign w_src_mask  = r_mask;
    assign w_src_lcin  = r_lcin;
    assign w_src_neg   = r_neg;
    assign w_src_prec  = r_prec;
    assign w_src_tag   = r_tag;
  end else begin : g_direct
    assign in_ready    = w_out_load;
    assign w_src_valid = in_valid;
    assign w_src_sum0  = w_sum0;
    assign w_src_sum1  = w_sum1;
    assign w_src_cout0 = w_cout0;
    assign w_src_cout1 = w_cout1;
    assign w_src_mask  = w_blk_mask;
    assign w_src_lcin  = w_lsb_cin;
    assign w_src_neg   = w_neg_eff;
    assign w_src_prec  = w_in_prec;
    assign w_src_tag   = in_tag;
  end

  // Carry select: restart the chain at every element LSB with that element's negate bit.
  always_comb begin
    logic carry;
    carry = 1'b0;
    w_res = '0;
    for (int b = 0; b < c_nblk; b++) begin
      if (w_src_mask[b])
        carry = w_src_lcin[b];
      w_res[b*BLOCK_W +: BLOCK_W] = carry ? w_src_sum1[b*BLOCK_W +: BLOCK_W]
                                          : w_src_sum0[b*BLOCK_W +: BLOCK_W];
      carry = carry ? w_src_cout1[b] : w_src_cout0[b];
    end
  end

  // Negation is a bijection, so a negated result of 100..0 implies the input was 100..0.
  always_comb begin
    w_ovf = '0;
    case (w_src_prec)
      PREC_8:
        for (int e = 0; e < c_nbyte; e++)
          w_ovf[e] = w_src_neg[e] && (w_res[e*8 +: 8] == 8'h80);
      PREC_16:
        for (int e = 0; e < DATA_W / 16; e++)
          w_ovf[e*2] = w_src_neg[e*2] && (w_res[e*16 +: 16] == 16'h8000);
      PREC_32:
        for (int e = 0; e < DATA_W / 32; e++)
          w_ovf[e*4] = w_src_neg[e*4] && (w_res[e*32 +: 32] == 32'h8000_0000);
      default: w_ovf = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
      out_tag   <= '0;
    end else if (w_out_load) begin
      out_valid <= w_src_valid;
      if (w_src_valid) begin
        out_data <= w_res;
        out_ovf  <= w_ovf;
        out_tag  <= w_src_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csel_negator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipelined_csel_negator : directed and scoreboarded negator checks     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipelined_csel_negator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  in_prec;
  logic [7:0]  in_neg;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_ovf;
  logic [3:0]  out_tag;

  int total = 0;
  int bad   = 0;
  int sent;
  int rx;
  logic acc;
  logic [75:0] q[$];
  logic [75:0] exp_item;

  localparam int NR = 400;

  pipelined_csel_negator #(
    .DATA_W(64), .BLOCK_W(4), .PIPE_STAGES(2), .TAG_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_prec(in_prec), .in_neg(in_neg), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic [1:0] p, input logic [7:0] ng, input logic [3:0] t);
    in_data = d;
    in_prec = p;
    in_neg  = ng;
    in_tag  = t;
  endtask

  // Single transaction on an idle pipe: accept, then result exactly two edges later.
  task automatic run_one(input string tag, input logic [63:0] d, input logic [1:0] p,
                         input logic [7:0] ng, input logic [3:0] t,
                         input logic [63:0] exp_d, input logic [7:0] exp_o);
    @(negedge clk);
    drive(d, p, ng, t);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_ovf"}, 64'(out_ovf), 64'(exp_o));
    check({tag, "_tag"}, 64'(out_tag), 64'(t));
  endtask

  // Element-wise arithmetic reference: returns {ovf, data}.
  function automatic logic [71:0] model(input logic [63:0] d, input logic [1:0] p, input logic [7:0] ng);
    logic [63:0] r;
    logic [7:0]  o;
    logic [31:0] x, m;
    int w;
    r = d;
    o = '0;
    if (p != 2'b11) begin
      w = 8 << p;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      for (int e = 0; e < 64 / w; e++) begin
        x = 32'(d >> (e * w)) & m;
        if (ng[(e * w) / 8]) begin
          if (x == (32'd1 << (w - 1))) o[(e * w) / 8] = 1'b1;
          x = (~x + 32'd1) & m;
        end
        r = (r & ~(64'(m) << (e * w))) | (64'(x) << (e * w));
      end
    end
    return {o, r};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(64'd0, 2'b00, 8'h00, 4'h0);
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;

    // Directed precision cases
    run_one("p8",      64'h7F01,                  2'b00, 8'h03, 4'h1, 64'h81FF,                  8'h00);
    run_one("p8_min",  64'h0000_0000_0000_0080,   2'b00, 8'h01, 4'h2, 64'h0000_0000_0000_0080,   8'h01);
    run_one("p16",     64'h0001_8000,             2'b01, 8'h05, 4'h3, 64'hFFFF_8000,             8'h01);
    run_one("p16_cry", 64'h0100,                  2'b01, 8'h01, 4'h4, 64'hFF00,                  8'h00);
    run_one("p16_hib", 64'h0001,                  2'b01, 8'h02, 4'h5, 64'h0001,                  8'h00);
    run_one("p32",     64'h0000_0001_FFFF_FFFF,   2'b10, 8'h11, 4'h6, 64'hFFFF_FFFF_0000_0001,   8'h00);
    run_one("p32_min", 64'h8000_0000_0000_0005,   2'b10, 8'h10, 4'h7, 64'h8000_0000_0000_0005,   8'h10);
    run_one("zero",    64'h0,                     2'b00, 8'hFF, 4'h8, 64'h0,                     8'h00);

    // Back-to-back stream with a 3-cycle downstream stall
    @(negedge clk);
    rx   = 0;
    sent = 0;
    for (int n = 0; n < 40 && rx < 6; n++) begin
      @(negedge clk);
      out_ready = !(n >= 3 && n <= 5);
      if (sent < 6) begin
        drive(64'(sent), 2'b00, 8'h00, sent[3:0]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (n >= 3 && n <= 5) check("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid) begin
        check("strm_tag", 64'(out_tag), 64'(rx));
        check("strm_data", out_data, 64'(rx));
      end
      if (out_valid && out_ready) rx++;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check("strm_count", 64'(rx), 64'd6);
    repeat (3) begin
      @(negedge clk);
      check("strm_nodup", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset with two items in flight
    @(negedge clk);
    out_ready = 1'b0;
    drive(64'h7F01, 2'b00, 8'h03, 4'h9);
    in_valid = 1'b1;
    @(negedge clk);
    drive(64'h1234, 2'b00, 8'h03, 4'hA);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", out_data, 64'd0);
    check("arst_ovf", 64'(out_ovf), 64'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_idle", 64'(out_valid), 64'd0);
    end

    run_one("rsvd", 64'h80, 2'b11, 8'hFF, 4'hB, 64'h80, 8'h00);

    // Random traffic against the reference model
    sent = 0;
    acc  = 1'b0;
    for (int n = 0; n < 4000 && (sent < NR || q.size() > 0); n++) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < NR && $urandom_range(0, 4) != 0) begin
        in_data = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) in_data = in_data & 64'h8080_8080_8080_8080;
        in_prec  = 2'($urandom_range(0, 3));
        in_neg   = 8'($urandom);
        in_tag   = 4'($urandom);
        in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL rnd_extra observed=unexpected_output expected=none");
        end
        if (q.size() != 0) begin
          exp_item = q.pop_front();
          check("rnd_data", out_data, exp_item[63:0]);
          check("rnd_ovf", 64'(out_ovf), 64'(exp_item[71:64]));
          check("rnd_tag", 64'(out_tag), 64'(exp_item[75:72]));
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back({in_tag, model(in_data, in_prec, in_neg)});
        sent++;
      end
    end
    in_valid = 1'b0;
    check("rnd_sent", 64'(sent), 64'(NR));
    check("rnd_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
